dcache_wb: RTL and testbench



---
 rtl/dcache_pkg.sv | 22 ++
 rtl/dcache_line_store.sv | 65 ++++++
 rtl/dcache_wb.sv | 154 +++++++++++++++
 tb/tb_dcache_wb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, line geometry and address-split helpers for the write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int OFFSET_BITS = 2;
    localparam int LINE_WORDS  = 4;
    localparam int LINE_BITS   = 64;

    function automatic int index_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int word_size, input int num_lines);
        return word_size - OFFSET_BITS - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/dirty/data arrays with combinational lookup, word write and line install.
// Lookup is zero-latency; writes land at posedge; no flow control (driven by the cache FSM).
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int  WORD_SIZE = 16,
    parameter int  NUM_LINES = 8,
    localparam int IDX_W     = index_bits(NUM_LINES),
    localparam int TAG_W     = tag_bits(WORD_SIZE, NUM_LINES),
    localparam int LW        = LINE_WORDS * WORD_SIZE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [IDX_W-1:0]       index,
    input  logic [TAG_W-1:0]       tag,
    input  logic [OFFSET_BITS-1:0] offset,
    output logic                   hit,
    output logic [WORD_SIZE-1:0]   rd_word,
    output logic                   victim_valid,
    output logic                   victim_dirty,
    output logic [TAG_W-1:0]       victim_tag,
    output logic [LW-1:0]          victim_line,
    input  logic                   word_we,
    input  logic [WORD_SIZE-1:0]   word_wdata,
    input  logic                   fill_we,
    input  logic [LW-1:0]          fill_line
);

    logic [NUM_LINES-1:0]                 valid_q;
    logic [NUM_LINES-1:0]                 dirty_q;
    logic [TAG_W-1:0]                     tag_q  [NUM_LINES];
    logic [LINE_WORDS-1:0][WORD_SIZE-1:0] data_q [NUM_LINES];

    // Only the state bits are reset; tags and data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[index]  <= tag;
            data_q[index] <= fill_line;
        end else if (word_we) begin
            data_q[index][offset] <= word_wdata;
        end
    end

    always_comb begin
        hit          = valid_q[index] && (tag_q[index] == tag);
        rd_word      = data_q[index][offset];
        victim_valid = valid_q[index];
        victim_dirty = dirty_q[index];
        victim_tag   = tag_q[index];
        victim_line  = data_q[index];
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back/write-allocate data cache: FSM, transfer timer and hit/miss stats.
// Hit completes in the request cycle; misses stall cpu_ready for 1 or 2 MEM_LATENCY line transfers.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int  WORD_SIZE   = 16,
    parameter int  NUM_LINES   = 8,
    parameter int  MEM_LATENCY = 6,
    parameter int  CNT_WIDTH   = 16,
    localparam int LW          = LINE_WORDS * WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [LW-1:0]        mem_wdata,
    input  logic [LW-1:0]        mem_rdata,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int IDX_W = index_bits(NUM_LINES);
    localparam int TAG_W = tag_bits(WORD_SIZE, NUM_LINES);
    localparam int LAT_W = $clog2(MEM_LATENCY + 1);

    logic [OFFSET_BITS-1:0] offset;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   victim_valid;
    logic                   victim_dirty;
    logic [TAG_W-1:0]       victim_tag;
    logic                   word_we;
    logic                   fill_we;
    logic                   req;
    logic                   lat_last;
    logic                   hit_inc;
    logic                   miss_inc;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             fill_done_q, fill_done_d;

    assign offset   = cpu_address[OFFSET_BITS-1:0];
    assign index    = cpu_address[OFFSET_BITS +: IDX_W];
    assign tag      = cpu_address[WORD_SIZE-1 -: TAG_W];
    assign req      = cpu_read | cpu_write;
    assign lat_last = (lat_q == LAT_W'(MEM_LATENCY - 1));

    dcache_line_store #(
        .WORD_SIZE (WORD_SIZE),
        .NUM_LINES (NUM_LINES)
    ) u_store (
        .clk          (clk),
        .reset_n      (reset_n),
        .index        (index),
        .tag          (tag),
        .offset       (offset),
        .hit          (hit),
        .rd_word      (cpu_rdata),
        .victim_valid (victim_valid),
        .victim_dirty (victim_dirty),
        .victim_tag   (victim_tag),
        .victim_line  (mem_wdata),
        .word_we      (word_we),
        .word_wdata   (cpu_wdata),
        .fill_we      (fill_we),
        .fill_line    (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            fill_done_q <= fill_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        fill_done_d = fill_done_q;
        cpu_ready   = 1'b0;
        word_we     = 1'b0;
        fill_we     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        unique case (state_q)
            IDLE: begin
                lat_d       = '0;
                fill_done_d = 1'b0;
                if (req) begin
                    if (hit) begin
                        // The replayed request after a fill completes here but is not a true hit.
                        cpu_ready = reset_n;
                        word_we   = cpu_write & reset_n;
                        hit_inc   = ~fill_done_q;
                    end else begin
                        miss_inc = 1'b1;
                        state_d  = (victim_valid && victim_dirty) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                mem_write   = 1'b1;
                mem_address = {victim_tag, index, {OFFSET_BITS{1'b0}}};
                if (lat_last) begin
                    lat_d   = '0;
                    state_d = ALLOCATE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = {tag, index, {OFFSET_BITS{1'b0}}};
                if (lat_last) begin
                    lat_d       = '0;
                    fill_we     = 1'b1;
                    fill_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc)  hit_count  <= hit_count + 1'b1;
            if (miss_inc) miss_count <= miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed vector bench for dcache_wb with a fixed-latency line memory model.
module tb_dcache_wb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    dcache_wb dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    // Line memory: a write commits only after the strobe has been held for 6 cycles.
    logic [63:0] mem [32];
    int          wcnt = 0;
    assign mem_rdata = mem[mem_address[6:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            if (wcnt == 5) mem[mem_address[6:2]] = mem_wdata;
            wcnt = wcnt + 1;
        end else begin
            wcnt = 0;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] rdata;
        logic        chk_rdata;
        int          n_rd;
        int          n_wr;
        logic [15:0] rd_addr;
        logic [15:0] wr_addr;
        logic [63:0] wr_line;
        int          hits;
        int          misses;
    } vec_t;

    vec_t vecs[15];

    // Entered and left at 1 time unit after a posedge.
    task automatic run_vec(input vec_t v, input int id);
        int          lat      = -1;
        logic [15:0] rdata    = '0;
        int          n_rd     = 0;
        int          n_wr     = 0;
        int          first_rd = -1;
        int          first_wr = -1;
        logic [15:0] rd_addr  = '0;
        logic [15:0] wr_addr  = '0;
        logic [63:0] wr_line  = '0;
        bit          both     = 0;
        bit          wchg     = 0;
        cpu_read    = v.rd;
        cpu_write   = v.wr;
        cpu_address = v.addr;
        cpu_wdata   = v.wdata;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) both = 1;
            if (mem_read) begin
                if (n_rd == 0) begin
                    first_rd = c;
                    rd_addr  = mem_address;
                end
                n_rd++;
            end
            if (mem_write) begin
                if (n_wr == 0) begin
                    first_wr = c;
                    wr_addr  = mem_address;
                    wr_line  = mem_wdata;
                end else if (mem_wdata !== wr_line || mem_address !== wr_addr) begin
                    wchg = 1;
                end
                n_wr++;
            end
            if (cpu_ready) begin
                lat   = c;
                rdata = cpu_rdata;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        check($sformatf("v%0d latency", id), 64'(lat), 64'(v.lat));
        if (v.chk_rdata) check($sformatf("v%0d rdata", id), 64'(rdata), 64'(v.rdata));
        check($sformatf("v%0d mem_read cycles", id), 64'(n_rd), 64'(v.n_rd));
        check($sformatf("v%0d mem_write cycles", id), 64'(n_wr), 64'(v.n_wr));
        if (v.n_rd > 0) begin
            check($sformatf("v%0d read start", id), 64'(first_rd), 64'(1 + v.n_wr));
            check($sformatf("v%0d read addr", id), 64'(rd_addr), 64'(v.rd_addr));
        end
        if (v.n_wr > 0) begin
            check($sformatf("v%0d write start", id), 64'(first_wr), 64'd1);
            check($sformatf("v%0d write addr", id), 64'(wr_addr), 64'(v.wr_addr));
            check($sformatf("v%0d write line", id), wr_line, v.wr_line);
        end
        check($sformatf("v%0d strobes overlap", id), 64'(both), 64'd0);
        check($sformatf("v%0d wb data stable", id), 64'(wchg), 64'd0);
        check($sformatf("v%0d hit_count", id), 64'(hit_count), 64'(v.hits));
        check($sformatf("v%0d miss_count", id), 64'(miss_count), 64'(v.misses));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        mem[0]  = 64'h0000_0000_0000_9023;
        mem[8]  = 64'h6000_0000_0000_0000;
        mem[9]  = 64'h7777_0000_0000_0000;
        mem[17] = 64'h4444_3333_2222_1111;

        //          rd wr addr      wdata     lat rdata     chk n_rd n_wr rd_addr   wr_addr   wr_line                hit miss
        vecs[0]  = '{1, 0, 16'h0023, 16'h0000, 7,  16'h6000, 1,  6,   0,   16'h0020, 16'h0000, 64'h0,                 0,  1};
        vecs[1]  = '{1, 0, 16'h0021, 16'h0000, 0,  16'h0000, 1,  0,   0,   16'h0000, 16'h0000, 64'h0,                 1,  1};
        vecs[2]  = '{0, 1, 16'h0022, 16'hABCD, 0,  16'h0000, 0,  0,   0,   16'h0000, 16'h0000, 64'h0,                 2,  1};
        vecs[3]  = '{1, 0, 16'h0022, 16'h0000, 0,  16'hABCD, 1,  0,   0,   16'h0000, 16'h0000, 64'h0,                 3,  1};
        vecs[4]  = '{1, 0, 16'h0003, 16'h0000, 13, 16'h0000, 1,  6,   6,   16'h0000, 16'h0020, 64'h6000_ABCD_0000_0000, 3, 2};
        vecs[5]  = '{1, 0, 16'h0000, 16'h0000, 0,  16'h9023, 1,  0,   0,   16'h0000, 16'h0000, 64'h0,                 4,  2};
        vecs[6]  = '{1, 0, 16'h0045, 16'h0000, 7,  16'h2222, 1,  6,   0,   16'h0044, 16'h0000, 64'h0,                 4,  3};
        vecs[7]  = '{1, 1, 16'h0001, 16'h1234, 0,  16'h0000, 0,  0,   0,   16'h0000, 16'h0000, 64'h0,                 5,  3};
        vecs[8]  = '{1, 0, 16'h0001, 16'h0000, 0,  16'h1234, 1,  0,   0,   16'h0000, 16'h0000, 64'h0,                 6,  3};
        vecs[9]  = '{1, 0, 16'h0000, 16'h0000, 7,  16'h9023, 1,  6,   0,   16'h0000, 16'h0000, 64'h0,                 0,  1};
        vecs[10] = '{1, 0, 16'h0000, 16'h0000, 7,  16'h9023, 1,  6,   0,   16'h0000, 16'h0000, 64'h0,                 0,  1};
        vecs[11] = '{0, 1, 16'h0024, 16'h5555, 7,  16'h0000, 0,  6,   0,   16'h0024, 16'h0000, 64'h0,                 0,  2};
        vecs[12] = '{1, 0, 16'h0024, 16'h0000, 0,  16'h5555, 1,  0,   0,   16'h0000, 16'h0000, 64'h0,                 1,  2};
        vecs[13] = '{1, 0, 16'h0027, 16'h0000, 0,  16'h7777, 1,  0,   0,   16'h0000, 16'h0000, 64'h0,                 2,  2};
        vecs[14] = '{1, 0, 16'h0004, 16'h0000, 13, 16'h0000, 1,  6,   6,   16'h0004, 16'h0024, 64'h7777_0000_0000_5555, 2, 3};

        // Reset with a request pending: ready must stay low.
        reset_n     = 1'b0;
        cpu_read    = 1'b1;
        cpu_write   = 1'b0;
        cpu_address = 16'h0000;
        cpu_wdata   = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset cpu_ready", 64'(cpu_ready), 64'd0);
        check("reset mem_read", 64'(mem_read), 64'd0);
        check("reset mem_write", 64'(mem_write), 64'd0);
        check("reset hit_count", 64'(hit_count), 64'd0);
        check("reset miss_count", 64'(miss_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        cpu_read = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset during cycle 3 of a dirty writeback of line 0x0000.
        cpu_read    = 1'b1;
        cpu_address = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("abort wb strobe", 64'(mem_write), 64'd1);
                check("abort wb addr", 64'(mem_address), 64'h0000);
                check("abort wb line", mem_wdata, 64'h0000_0000_1234_9023);
            end
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check("abort wb cycle3 strobe", 64'(mem_write), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort mem_write", 64'(mem_write), 64'd0);
        check("abort mem_read", 64'(mem_read), 64'd0);
        check("abort hit_count", 64'(hit_count), 64'd0);
        check("abort miss_count", 64'(miss_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        cpu_read = 1'b0;
        run_vec(vecs[9], 9);

        // Line 0 is now valid: a would-be hit while in reset must not complete or count.
        cpu_read    = 1'b1;
        cpu_address = 16'h0000;
        reset_n     = 1'b0;
        @(negedge clk);
        check("reset gates ready", 64'(cpu_ready), 64'd0);
        @(posedge clk);
        #1;
        check("reset gates hit_count", 64'(hit_count), 64'd0);
        reset_n  = 1'b1;
        cpu_read = 1'b0;

        for (int i = 10; i < 15; i++) run_vec(vecs[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
